// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the address-qualification helper for the
// parametrised register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 64;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_ZERO_REG = 31;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [63:0] reg_data_t;

    // True for the hardwired-zero index or any index past the last register;
    // such an address is never written and always reads back as zero.
    function automatic logic is_zero_or_oob(input int addr, input int num_regs,
                                            input int zero_reg);
        return (addr == zero_reg) || (addr >= num_regs);
    endfunction

endpackage

// File: rtl/reg_write_decoder.sv
// One-hot write-row decoder: a row enable is raised only for an enabled write
// to an in-range register other than the hardwired-zero one.
module reg_write_decoder
    import regfile_pkg::*;
#(
    parameter int  NUM_REGS = DEFAULT_NUM_REGS,
    parameter int  ZERO_REG = DEFAULT_ZERO_REG,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);

    logic addr_ok;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        onehot  = '0;
        addr_ok = !is_zero_or_oob(int'(addr), NUM_REGS, ZERO_REG);
        for (int i = 0; i < NUM_REGS; i++) begin
            // en is ANDed first so an unknown address cannot raise a row while idle
            onehot[i] = en && addr_ok && (int'(addr) == i);
        end
    end

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file: NUM_RD combinational read ports, one write port,
// hardwired-zero register. Define REGFILE_BYPASS_EN for same-cycle write-through.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = DEFAULT_DATA_W,
    parameter int  NUM_REGS = DEFAULT_NUM_REGS,
    parameter int  NUM_RD   = 2,
    parameter int  ZERO_REG = DEFAULT_ZERO_REG,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WriteRegister,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    output logic [NUM_RD*DATA_W-1:0] ReadData
);

    logic [NUM_REGS-1:0] row_we;
    logic [DATA_W-1:0]   rows [NUM_REGS];
    logic [ADDR_W-1:0]   rd_addr;

    reg_write_decoder #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_write_decoder (
        .en     (RegWrite),
        .addr   (WriteRegister),
        .onehot (row_we)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_row
        logic [DATA_W-1:0] row_d;
        logic [DATA_W-1:0] row_q;

        always_comb begin
            row_d = row_q;
            if (row_we[i]) begin
                row_d = WriteData;
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        // NOTE: each row carries an async clear because reset must zero the
        // whole file immediately; RAM-style arrays usually omit storage reset.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                row_q <= '0;
            end else begin
                row_q <= row_d;
            end
        end

        assign rows[i] = row_q;
    end

    always_comb begin
        ReadData = '0;
        rd_addr  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr = ReadRegister[p*ADDR_W +: ADDR_W];
            if (!is_zero_or_oob(int'(rd_addr), NUM_REGS, ZERO_REG)) begin
                ReadData[p*DATA_W +: DATA_W] = rows[rd_addr];
`ifdef REGFILE_BYPASS_EN
                // Forward the in-flight write so decode sees it without a stall
                if (RegWrite && !reset && (rd_addr == WriteRegister)) begin
                    ReadData[p*DATA_W +: DATA_W] = WriteData;
                end
`else
`endif
            end
        end
    end

endmodule
